latch_readback: RTL and testbench

LATCH_READBACK -- requirements
Module: latch_readback

---
 rtl/latch_pkg.sv | 27 ++
 rtl/latch_readback.sv | 142 ++++++++++++++
 tb/tb_latch_readback.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/latch_pkg.sv
// ============================================================================
// latch_pkg: register offsets and readback FSM encoding shared by the
// config latch write and readback paths.
// Revision: 1.0
// ============================================================================
`default_nettype none

package latch_pkg;

    localparam logic [5:0] ADDR_DATA_LO = 6'h08;
    localparam logic [5:0] ADDR_DATA_HI = 6'h0C;
    localparam logic [5:0] ADDR_RB_CMD  = 6'h10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_SETTLE = 2'b10,
        ST_DONE   = 2'b11
    } rb_state_e;

    function automatic int idx_bits(input int num_regs);
        return (num_regs > 16) ? 5 : ((num_regs > 8) ? 4 : 3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/latch_readback.sv
// ============================================================================
// latch_readback: selects one config latch, waits for the shared read bus to
// settle, captures 48 bits and serves them over a small CPU register window.
// Optional macro LATCH_READBACK_SCAN_EN: reading the high word auto-advances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module latch_readback
    import latch_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_req,
    input  logic                read_req,
    input  logic [5:0]          address,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    input  logic [47:0]         latch_rdata,
    output logic [NUM_REGS-1:0] latch_sel,
    output logic                busy
);

    localparam int IDX_BITS = idx_bits(NUM_REGS);

    rb_state_e           state;
    rb_state_e           state_nxt;
    logic [IDX_BITS-1:0] index;
    logic [47:0]         buffer;
    logic                valid;
    logic                err;
    logic                scan_pend;
    logic                cmd_hit;
    logic                accept;
    logic                reject;
    logic                start;
    logic                sel_active;
    logic [31:0]         rd_mux;

    // Range is judged on the full write value so large indices are not
    // silently aliased onto a valid latch by truncation.
    assign cmd_hit    = write_req && (address == ADDR_RB_CMD) && (state == ST_IDLE) && !scan_pend;
    assign accept     = cmd_hit && (data_in < 32'(NUM_REGS));
    assign reject     = cmd_hit && !(data_in < 32'(NUM_REGS));
    assign start      = accept || scan_pend;
    assign busy       = (state != ST_IDLE);
    assign sel_active = (state == ST_SELECT) || (state == ST_SETTLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SELECT;
            ST_SELECT: state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            latch_sel[i] = sel_active && (index == IDX_BITS'(i));
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            ADDR_DATA_LO: rd_mux = buffer[31:0];
            ADDR_DATA_HI: rd_mux = {16'h0, buffer[47:32]};
            ADDR_RB_CMD:  rd_mux = {busy, valid, err, 24'h0, 5'(index)};
            default:      rd_mux = 32'h0;
        endcase
    end

`ifdef LATCH_READBACK_SCAN_EN
    logic scan_hit;
    assign scan_hit = read_req && (address == ADDR_DATA_HI) && (state == ST_IDLE)
                      && valid && !cmd_hit && !scan_pend;
`else
    assign scan_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index    <= '0;
            buffer   <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            data_out <= 32'h0;
        end else begin
            if (accept) begin
                index <= data_in[IDX_BITS-1:0];
                err   <= 1'b0;
                valid <= 1'b0;
            end else if (reject) begin
                err   <= 1'b1;
                valid <= 1'b0;
            end
`ifdef LATCH_READBACK_SCAN_EN
            // The auto-started sequence behaves like a fresh accept.
            if (scan_hit) begin
                index <= (index == IDX_BITS'(NUM_REGS - 1)) ? '0 : index + IDX_BITS'(1);
            end else if (scan_pend) begin
                err   <= 1'b0;
                valid <= 1'b0;
            end
`endif
            if (state == ST_SETTLE) begin
                buffer <= latch_rdata;
                valid  <= 1'b1;
            end
            if (read_req) begin
                data_out <= rd_mux;
            end
        end
    end

`ifdef LATCH_READBACK_SCAN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_pend <= 1'b0;
        end else begin
            scan_pend <= scan_hit;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_latch_readback.sv
// ============================================================================
// tb_latch_readback: table-driven directed checks of latch_readback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_latch_readback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_req;
    logic        read_req;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [47:0] latch_rdata;
    logic [7:0]  latch_sel;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam logic [47:0] L1 = 48'hABCD_1234_5678;
    localparam logic [47:0] L2 = 48'h1111_2222_3333;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] din;
        logic [47:0] lrd;
        logic [7:0]  exp_sel;
        logic        exp_busy;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vec [23];

    latch_readback #(.NUM_REGS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_req   (write_req),
        .read_req    (read_req),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .latch_rdata (latch_rdata),
        .latch_sel   (latch_sel),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [5:0] addr,
                                input logic [31:0] din, input logic [47:0] lrd,
                                input logic [7:0] esel, input logic ebusy,
                                input logic [31:0] edout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.din = din; v.lrd = lrd;
        v.exp_sel = esel; v.exp_busy = ebusy; v.exp_dout = edout;
        return v;
    endfunction

    initial begin
        // Outputs checked in each row reflect the edges before it; inputs apply to the next edge.
        vec[0]  = mk(1, 0, 6'h10, 3, L1, 8'h00, 0, 32'h0000_0000);
        vec[1]  = mk(0, 0, 6'h00, 0, L1, 8'h08, 1, 32'h0000_0000);
        vec[2]  = mk(0, 0, 6'h00, 0, L1, 8'h08, 1, 32'h0000_0000);
        vec[3]  = mk(0, 1, 6'h0C, 0, L1, 8'h00, 1, 32'h0000_0000);
        vec[4]  = mk(0, 1, 6'h08, 0, L1, 8'h00, 0, 32'h0000_ABCD);
        vec[5]  = mk(0, 1, 6'h10, 0, L1, 8'h00, 0, 32'h1234_5678);
        vec[6]  = mk(0, 0, 6'h00, 0, L1, 8'h00, 0, 32'h4000_0003);
        vec[7]  = mk(0, 0, 6'h00, 0, L1, 8'h00, 0, 32'h4000_0003);
        vec[8]  = mk(0, 1, 6'h08, 0, L1, 8'h00, 0, 32'h4000_0003);
        vec[9]  = mk(1, 1, 6'h10, 2, L1, 8'h00, 0, 32'h1234_5678);
        vec[10] = mk(0, 1, 6'h08, 0, L1, 8'h04, 1, 32'h4000_0003);
        vec[11] = mk(0, 1, 6'h10, 0, L2, 8'h04, 1, 32'h1234_5678);
        vec[12] = mk(0, 1, 6'h0C, 0, L2, 8'h00, 1, 32'h8000_0002);
        vec[13] = mk(0, 1, 6'h08, 0, L2, 8'h00, 0, 32'h0000_1111);
        vec[14] = mk(0, 1, 6'h3C, 0, L2, 8'h00, 0, 32'h2222_3333);
        vec[15] = mk(1, 0, 6'h10, 9, L2, 8'h00, 0, 32'h0000_0000);
        vec[16] = mk(0, 1, 6'h10, 0, L2, 8'h00, 0, 32'h0000_0000);
        vec[17] = mk(1, 0, 6'h10, 5, L2, 8'h00, 0, 32'h2000_0002);
        vec[18] = mk(1, 0, 6'h10, 6, L2, 8'h20, 1, 32'h2000_0002);
        vec[19] = mk(0, 1, 6'h10, 0, L2, 8'h20, 1, 32'h2000_0002);
        vec[20] = mk(0, 0, 6'h00, 0, L2, 8'h00, 1, 32'h8000_0005);
        vec[21] = mk(0, 1, 6'h10, 0, L2, 8'h00, 0, 32'h8000_0005);
        vec[22] = mk(0, 0, 6'h00, 0, L2, 8'h00, 0, 32'h4000_0005);

        rst_n = 1'b0; write_req = 1'b0; read_req = 1'b0;
        address = 6'h0; data_in = 32'h0; latch_rdata = 48'h0;
        step();
        step();
        chk("reset_sel", 32'(latch_sel), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_dout", data_out, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            write_req   = vec[i].wr;
            read_req    = vec[i].rd;
            address     = vec[i].addr;
            data_in     = vec[i].din;
            latch_rdata = vec[i].lrd;
            chk($sformatf("v%0d_sel", i), 32'(latch_sel), 32'(vec[i].exp_sel));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].exp_busy));
            chk($sformatf("v%0d_dout", i), data_out, vec[i].exp_dout);
            step();
        end
        write_req = 1'b0; read_req = 1'b0;

        // Reset asserted while SETTLE: selection drops, no capture, buffer cleared.
        write_req = 1'b1; address = 6'h10; data_in = 32'd4; latch_rdata = L1;
        step();
        write_req = 1'b0;
        step();
        chk("rst_mid_settle_sel", 32'(latch_sel), 32'h10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_sel", 32'(latch_sel), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        read_req = 1'b1; address = 6'h08;
        step();
        chk("rst_mid_lo", data_out, 32'h0);
        address = 6'h10;
        step();
        read_req = 1'b0;
        chk("rst_mid_status", data_out, 32'h0);

        // Index 7 captured, then a high-word read while idle.
        write_req = 1'b1; address = 6'h10; data_in = 32'd7; latch_rdata = L1;
        step();
        write_req = 1'b0;
        chk("scan_sel7", 32'(latch_sel), 32'h80);
        step();
        step();
        step();
        chk("scan_idle_busy", 32'(busy), 32'h0);
        read_req = 1'b1; address = 6'h0C;
        step();
        read_req = 1'b0;
        chk("scan_hi", data_out, 32'h0000_ABCD);
        chk("scan_sel_gap", 32'(latch_sel), 32'h0);
        step();
`ifdef LATCH_READBACK_SCAN_EN
        chk("scan_wrap_sel", 32'(latch_sel), 32'h01);
        chk("scan_busy", 32'(busy), 32'h1);
`else
        chk("noscan_sel", 32'(latch_sel), 32'h0);
        chk("noscan_busy", 32'(busy), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
